// File: rtl/modo_contador_ctrl.sv
// Command sequencer for the 4-bit multi-mode counter.
// Two requesters share the counter through a round-robin grant. Each granted command:
// - loads its start value,
// - runs the counter for the requested number of steps,
// - counts rco events during the run,
// - returns the final q.
module modo_contador_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned RCO_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       mode0,
  input  logic [1:0]       mode1,
  input  logic [3:0]       d0,
  input  logic [3:0]       d1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             enable,
  output logic [1:0]       modo,
  output logic [3:0]       d,
  input  logic [3:0]       q,
  input  logic             rco,
  output logic [3:0]       result_q,
  output logic [RCO_W-1:0] rco_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_t;

  state_t           state_q;
  logic             last_q;   // requester granted most recently (1 -> favour req0)
  logic             gnt_q;    // requester owning the command in flight
  logic [1:0]       mode_q;
  logic [3:0]       d_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;    // RUN cycles still to go, including the current one

  logic             sel1;
  logic [1:0]       sel_mode;
  logic [3:0]       sel_d;
  logic [LEN_W-1:0] sel_len;

  // Grant selection: a lone requester wins; on a tie the one not granted last wins
  always_comb begin
    sel1     = req1 & (~req0 | ~last_q);
    sel_mode = sel1 ? mode1 : mode0;
    sel_d    = sel1 ? d1 : d0;
    sel_len  = sel1 ? len1 : len0;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      mode_q    <= 2'd0;
      d_q       <= 4'd0;
      len_q     <= '0;
      cnt_q     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      enable    <= 1'b0;
      modo      <= 2'd0;
      d         <= 4'd0;
      result_q  <= 4'd0;
      rco_count <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy   <= 1'b0;
          enable <= 1'b0;
          modo   <= 2'd0;
          d      <= 4'd0;
          if (req0 || req1) begin
            gnt_q     <= sel1;
            last_q    <= sel1;
            mode_q    <= sel_mode;
            d_q       <= sel_d;
            len_q     <= sel_len;
            rco_count <= '0;
            ack0      <= ~sel1;
            ack1      <= sel1;
            busy      <= 1'b1;
            enable    <= 1'b1;
            modo      <= 2'd3;
            d         <= sel_d;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          // A load command or an empty run has nothing to step
          if (len_q == '0 || mode_q == 2'd3) begin
            enable  <= 1'b0;
            state_q <= StDone;
          end else begin
            enable  <= 1'b1;
            modo    <= mode_q;
            cnt_q   <= len_q;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (rco && rco_count != {RCO_W{1'b1}}) begin
            rco_count <= rco_count + 1'b1;
          end
          if (cnt_q == LEN_W'(1)) begin
            enable  <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          result_q <= q;
          done0    <= ~gnt_q;
          done1    <= gnt_q;
          busy     <= 1'b0;
          enable   <= 1'b0;
          modo     <= 2'd0;
          d        <= 4'd0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_modo_contador_ctrl.sv
// Bench for modo_contador_ctrl: behavioural counter model, directed commands with
// hand-computed results, scoreboard queues checked by an independent monitor.
module tb_modo_contador_ctrl;

  localparam int LEN_W = 8;
  localparam int RCO_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [1:0]       mode0, mode1;
  logic [3:0]       d0, d1;
  logic [LEN_W-1:0] len0, len1;
  logic             ack0, ack1, done0, done1, busy, enable;
  logic [1:0]       modo;
  logic [3:0]       d, q, result_q;
  logic             rco;
  logic [RCO_W-1:0] rco_count;

  modo_contador_ctrl #(.LEN_W(LEN_W), .RCO_W(RCO_W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .d0(d0), .d1(d1), .len0(len0), .len1(len1), .ack0(ack0), .ack1(ack1),
    .done0(done0), .done1(done1), .busy(busy), .enable(enable), .modo(modo), .d(d),
    .q(q), .rco(rco), .result_q(result_q), .rco_count(rco_count)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit multi-mode counter
  logic [3:0] cq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cq <= 4'd0;
    else if (enable) begin
      case (modo)
        2'd0:    cq <= cq + 4'd1;
        2'd1:    cq <= cq - 4'd1;
        2'd2:    cq <= cq - 4'd3;
        default: cq <= d;
      endcase
    end
  end
  assign q   = cq;
  assign rco = (modo == 2'd0 && cq == 4'd15) || ((modo == 2'd1 || modo == 2'd2) && cq == 4'd0);

  typedef struct {
    int id;
    int res;
    int rcnt;
    int en;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   ackq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int res, input int rcnt, input int en, input int lat);
    exp_t e;
    e.id = id; e.res = res; e.rcnt = rcnt; e.en = en; e.lat = lat;
    sb.push_back(e);
    ackq.push_back(id);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expected acks and completions as the DUT presents them
  int en_cnt = 0;
  int ack_cyc = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (ack0 || ack1) begin
        chk("two_acks", int'(ack0 & ack1), 0);
        en_cnt  = 0;
        ack_cyc = cyc;
        if (ackq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none", ack0, ack1);
        end else begin
          chk("ack_id", ack1 ? 1 : 0, ackq.pop_front());
        end
      end
      if (enable) en_cnt++;
      if (done0 || done1) begin
        chk("two_dones", int'(done0 & done1), 0);
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b, expected none", done0, done1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_id", done1 ? 1 : 0, e.id);
          chk("result_q", int'(result_q), e.res);
          chk("rco_count", int'(rco_count), e.rcnt);
          chk("enable_cycles", en_cnt, e.en);
          chk("done_latency", cyc - ack_cyc, e.lat);
        end
      end
    end
  end

  task automatic wait_ack(input int id);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if ((id == 0 && ack0) || (id == 1 && ack1)) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: got no ack%0d, expected one within 50 cycles", id);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done0 || done1) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done, expected one within 400 cycles");
    end
  endtask

  // Issue one command; expected values are computed by hand per vector
  task automatic issue(input int id, input int mode, input int dv, input int len,
                       input int res, input int rcnt, input int en, input int lat);
    push(id, res, rcnt, en, lat);
    if (id == 0) begin
      mode0 = 2'(mode); d0 = 4'(dv); len0 = LEN_W'(len); req0 = 1'b1;
    end else begin
      mode1 = 2'(mode); d1 = 4'(dv); len1 = LEN_W'(len); req1 = 1'b1;
    end
    wait_ack(id);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    rst = 1'b0;
    // Both requesters pending from reset: req0 mode0 d2 len1 -> q 2->3; req1 mode1 d1 len2 -> 1,0,15
    req0 = 1'b1; mode0 = 2'd0; d0 = 4'd2; len0 = LEN_W'(1);
    req1 = 1'b1; mode1 = 2'd1; d1 = 4'd1; len1 = LEN_W'(2);
    #23;
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_ack1", int'(ack1), 0);
    chk("rst_done", int'(done0 | done1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_modo", int'(modo), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_result_q", int'(result_q), 0);
    chk("rst_rco_count", int'(rco_count), 0);
    push(0, 3, 0, 2, 3);
    push(1, 15, 1, 3, 4);
    push(0, 3, 0, 2, 3);
    push(1, 15, 1, 3, 4);
    @(negedge clk);
    rst = 1'b1;

    // Round-robin under continuous contention
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (ack0 || ack1) ok = 1;
      end
      if (!ok) begin
        n_cmp++; n_err++;
        $display("FAIL rr_ack_timeout: got no ack, expected grant %0d", k);
        break;
      end
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        if (ack0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
      end
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);

    issue(0, 0, 0, 5, 5, 0, 6, 7);    // up from 0 for 5 steps
    issue(1, 0, 14, 3, 1, 1, 4, 5);   // 14,15,0,1: one rco in RUN
    issue(0, 2, 14, 2, 8, 0, 3, 4);   // 14,11,8
    issue(0, 1, 0, 1, 15, 1, 2, 3);   // 0 -> 15, rco at q=0
    issue(0, 3, 9, 7, 9, 0, 1, 2);    // load mode: no RUN
    issue(1, 0, 4, 0, 4, 0, 1, 2);    // len 0: no RUN

    // Abort in the 3rd RUN cycle of a long command
    ackq.push_back(0);
    mode0 = 2'd0; d0 = 4'd0; len0 = LEN_W'(10); req0 = 1'b1;
    wait_ack(0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_enable", int'(enable), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'(ack0 | ack1), 0);
    chk("abort_done", int'(done0 | done1), 0);
    chk("abort_result_q", int'(result_q), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    issue(1, 0, 7, 2, 9, 0, 3, 4);    // served normally after abort: 7,8,9

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("ackq_drained", ackq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
